topk_result_serializer: RTL and testbench

TOPK_RESULT_SERIALIZER -- requirements
Module: topk_result_serializer

---
 rtl/topk_pkg.sv | 18 +
 rtl/topk_result_serializer_if.sv | 28 ++
 rtl/topk_vec_fifo.sv | 58 +++++
 rtl/topk_result_serializer.sv | 116 +++++++++++
 tb/tb_topk_result_serializer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/topk_pkg.sv
// rtl/topk_pkg.sv - element type and serializer state shared with the partial sorter
package topk_pkg;

    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] elem_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ser_state_e;

    // M=0 still needs a one-bit index so the port has a legal width
    function automatic int idx_width(input int m);
        return (m > 0) ? m : 1;
    endfunction

endpackage

// File: rtl/topk_result_serializer_if.sv
// rtl/topk_result_serializer_if.sv - vector input strobe and element output stream
interface topk_result_serializer_if #(
    parameter int M = 3
);
    import topk_pkg::*;

    localparam int K     = 2 ** M;
    localparam int IDX_W = idx_width(M);

    logic                  in_valid;
    logic [K*DATA_W-1:0]   in_data;
    logic                  out_valid;
    logic                  out_ready;
    elem_t                 out_data;
    logic [IDX_W-1:0]      out_idx;
    logic                  out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_idx, out_last
    );

endinterface

// File: rtl/topk_vec_fifo.sv
// rtl/topk_vec_fifo.sv - DEPTH-entry vector FIFO; a push into a full FIFO lands only when a pop frees the slot
module topk_vec_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [W-1:0]           i_push_data,
    input  logic                   i_pop,
    output logic [W-1:0]           o_head,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [W-1:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_count;
    logic               w_wr;

    assign o_full  = (r_count == FULL_LVL);
    assign o_empty = (r_count == '0);
    assign w_wr    = i_push && (!o_full || i_pop);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_level = r_count;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/topk_result_serializer.sv
// rtl/topk_result_serializer.sv - buffers top-K vectors and streams them one element per handshake
// Optional drop counter output enabled by TOPK_SER_DROP_COUNT_EN.
module topk_result_serializer
    import topk_pkg::*;
#(
    parameter int M     = 3,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    topk_result_serializer_if.slave   bus,
    input  logic                      ovf_clr,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow
`ifdef TOPK_SER_DROP_COUNT_EN
    ,
    output logic [15:0]               drop_count
`endif
);
    localparam int K     = 2 ** M;
    localparam int IDX_W = idx_width(M);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);
    localparam logic [LVL_W-1:0] ONE_LVL  = LVL_W'(1);

    ser_state_e             r_state;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_overflow;

    logic [K*DATA_W-1:0]    w_head;
    logic [LVL_W-1:0]       w_level;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_send;
    logic                   w_pop;
    logic                   w_drop;

    assign w_send = (r_state == S_SEND);
    assign w_pop  = w_send && bus.out_ready && (r_idx == LAST_IDX);
    assign w_drop = bus.in_valid && w_full && !w_pop;

    topk_vec_fifo #(
        .W     (K * DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (bus.in_valid),
        .i_push_data (bus.in_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_level     (w_level),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Leave SEND only when the last element of the last stored vector goes out and nothing arrives alongside it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid || !w_empty) begin
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (bus.out_ready) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx <= '0;
                            if (w_level == ONE_LVL && !bus.in_valid) begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef TOPK_SER_DROP_COUNT_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_count <= '0;
        end else if (ovf_clr) begin
            r_drop_count <= {15'd0, w_drop};
        end else if (w_drop && r_drop_count != 16'hFFFF) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`endif

    assign bus.out_valid = w_send;
    assign bus.out_data  = w_send ? elem_t'(w_head[r_idx*DATA_W +: DATA_W]) : '0;
    assign bus.out_idx   = r_idx;
    assign bus.out_last  = w_send && (r_idx == LAST_IDX);
    assign level         = w_level;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_topk_result_serializer.sv
// tb/tb_topk_result_serializer.sv - directed checks of topk_result_serializer with M=3, DEPTH=4
module tb_topk_result_serializer;
    import topk_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [2:0] level;
    logic       overflow;
`ifdef TOPK_SER_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    topk_result_serializer_if #(.M(3)) bus ();

    topk_result_serializer #(
        .M     (3),
        .DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ovf_clr  (ovf_clr),
        .level    (level),
        .overflow (overflow)
`ifdef TOPK_SER_DROP_COUNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] mk(input int base, input int step);
        logic [127:0] v;
        for (int i = 0; i < 8; i++) begin
            v[i*16 +: 16] = 16'(base + step * i);
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_elem(input string tag, input int base, input int step, input int i);
        elem_t e;
        e = elem_t'(base + step * i);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_data"}, bus.out_data, e);
        check({tag, "_idx"}, 32'(bus.out_idx), 32'(i));
        check({tag, "_last"}, 32'(bus.out_last), 32'(i == 7));
    endtask

    task automatic push(input int base, input int step);
        bus.in_valid = 1'b1;
        bus.in_data  = mk(base, step);
    endtask

    task automatic drain(input string tag, input int base, input int step);
        for (int i = 0; i < 8; i++) begin
            expect_elem(tag, base, step, i);
            tick();
        end
    endtask

    initial begin
        int b3[3];
        int s3[3];
        b3 = '{70, -100, 1000};
        s3 = '{-10, -100, 3};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // reset state
        repeat (2) tick();
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", bus.out_data, 32'd0);
        check("rst_idx", 32'(bus.out_idx), 32'd0);
        check("rst_last", 32'(bus.out_last), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
`ifdef TOPK_SER_DROP_COUNT_EN
        check("rst_dc", 32'(drop_count), 32'd0);
`endif
        rst_n = 1'b1;
        tick();
        check("idle_valid", 32'(bus.out_valid), 32'd0);

        // single vector, always ready
        bus.out_ready = 1'b1;
        push(70, -10);
        tick();
        bus.in_valid = 1'b0;
        check("t1_level", 32'(level), 32'd1);
        drain("t1", 70, -10);
        check("t1_end_valid", 32'(bus.out_valid), 32'd0);
        check("t1_end_level", 32'(level), 32'd0);

        // single vector, ready alternating 0,1
        bus.out_ready = 1'b0;
        push(70, -10);
        tick();
        bus.in_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            bus.out_ready = c[0];
            expect_elem("t2", 70, -10, c / 2);
            tick();
        end
        check("t2_end_valid", 32'(bus.out_valid), 32'd0);
        check("t2_end_level", 32'(level), 32'd0);

        // three back-to-back vectors
        bus.out_ready = 1'b1;
        push(b3[0], s3[0]);
        tick();
        for (int c = 0; c < 24; c++) begin
            expect_elem("t3", b3[c / 8], s3[c / 8], c % 8);
            if (c == 2) begin
                check("t3_level_peak", 32'(level), 32'd3);
            end
            if (c == 0) begin
                bus.in_data = mk(b3[1], s3[1]);
            end else if (c == 1) begin
                bus.in_data = mk(b3[2], s3[2]);
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
        end
        check("t3_end_valid", 32'(bus.out_valid), 32'd0);
        check("t3_end_level", 32'(level), 32'd0);

        // six pushes with downstream stalled
        bus.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            push(100 * (k + 1), 1);
            tick();
            bus.in_valid = 1'b0;
            check("t4_level", 32'(level), 32'((k < 4) ? k + 1 : 4));
            check("t4_ovf", 32'(overflow), 32'(k >= 4));
        end
`ifdef TOPK_SER_DROP_COUNT_EN
        check("t4_dc", 32'(drop_count), 32'd2);
`endif
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drain("t4", 100 * (k + 1), 1);
        end
        check("t4_end_valid", 32'(bus.out_valid), 32'd0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t4_clr_ovf", 32'(overflow), 32'd0);
`ifdef TOPK_SER_DROP_COUNT_EN
        check("t4_clr_dc", 32'(drop_count), 32'd0);
`endif

        // full FIFO: push alongside last-element pop, then drop alongside clear
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push(-2000 + 50 * k, 7);
            tick();
        end
        bus.in_valid = 1'b0;
        check("t5_full_level", 32'(level), 32'd4);
        bus.out_ready = 1'b1;
        for (int j = 0; j < 7; j++) begin
            expect_elem("t5_x0", -2000, 7, j);
            tick();
        end
        expect_elem("t5_x0", -2000, 7, 7);
        push(-1800, 7);
        tick();
        bus.in_valid = 1'b0;
        check("t5_swap_level", 32'(level), 32'd4);
        check("t5_swap_ovf", 32'(overflow), 32'd0);
        expect_elem("t5_x1_first", -1950, 7, 0);
        bus.out_ready = 1'b0;
        push(-1750, 7);
        ovf_clr = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        ovf_clr = 1'b0;
        check("t5_dropclr_ovf", 32'(overflow), 32'd1);
        check("t5_dropclr_level", 32'(level), 32'd4);
`ifdef TOPK_SER_DROP_COUNT_EN
        check("t5_dropclr_dc", 32'(drop_count), 32'd1);
`endif
        expect_elem("t5_hold", -1950, 7, 0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t5_clr_ovf", 32'(overflow), 32'd0);
`ifdef TOPK_SER_DROP_COUNT_EN
        check("t5_clr_dc", 32'(drop_count), 32'd0);
`endif
        bus.out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            drain("t5_drain", -2000 + 50 * k, 7);
        end
        check("t5_end_valid", 32'(bus.out_valid), 32'd0);
        check("t5_end_level", 32'(level), 32'd0);

        // reset in the middle of a vector
        bus.out_ready = 1'b0;
        push(5, 1);
        tick();
        push(10, 1);
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        expect_elem("t6_mid", 5, 1, 3);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        check("t6_rst_data", bus.out_data, 32'd0);
        check("t6_rst_idx", 32'(bus.out_idx), 32'd0);
        check("t6_rst_last", 32'(bus.out_last), 32'd0);
        check("t6_rst_level", 32'(level), 32'd0);
        check("t6_rst_ovf", 32'(overflow), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t6_post_valid", 32'(bus.out_valid), 32'd0);
        end
        check("t6_post_level", 32'(level), 32'd0);
        push(15, 1);
        tick();
        bus.in_valid = 1'b0;
        check("t6_new_level", 32'(level), 32'd1);
        drain("t6_new", 15, 1);
        check("t6_end_valid", 32'(bus.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
